// File: rtl/vector_pkg.sv
// Shared types and helpers for the vector item streamer.
package vector_pkg;

    localparam int DEF_LANES = 20;
    localparam int DEF_WIDTH = 10;

    typedef enum logic [1:0] {IDLE, RUN, DONE} stream_state_t;

    // Lane step that stays inside [0, lanes) given idx, stride < lanes.
    function automatic int unsigned wrap_add(input int unsigned idx,
                                             input int unsigned stride,
                                             input int unsigned lanes);
        int unsigned sum;
        sum = idx + stride;
        if (sum >= lanes)
            sum = sum - lanes;
        return sum;
    endfunction

endpackage

// File: rtl/lane_index_stepper.sv
// Holds the current lane index, the remaining visit count and the captured stride.
module lane_index_stepper
    import vector_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int AW    = (LANES > 1) ? $clog2(LANES) : 1,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] stride,
    input  logic [CW-1:0] count,
    output logic [AW-1:0] idx,
    output logic [CW-1:0] rem,
    output logic          last
);

    logic [AW-1:0] idx_p0;
    logic [CW-1:0] rem_p0;
    logic [AW-1:0] stride_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_p0    <= '0;
            rem_p0    <= '0;
            stride_p0 <= '0;
        end else if (load) begin
            idx_p0    <= base;
            rem_p0    <= count;
            stride_p0 <= stride;
        end else if (step) begin
            idx_p0 <= AW'(wrap_add(32'(idx_p0), 32'(stride_p0), LANES));
            rem_p0 <= rem_p0 - CW'(1);
        end
    end

    assign idx  = idx_p0;
    assign rem  = rem_p0;
    assign last = (rem_p0 == CW'(1));

endmodule

// File: rtl/vector_item_streamer.sv
// Captures a vector and streams base, base+stride, ... (mod LANES) one element per handshake.
// Optional lane masking is enabled by defining VECTOR_STREAM_MASK_EN.
module vector_item_streamer
    import vector_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = (LANES > 1) ? $clog2(LANES) : 1,
    parameter int CW    = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [LANES-1:0][WIDTH-1:0] vec_in,
    input  logic [AW-1:0]               base,
    input  logic [AW-1:0]               stride,
    input  logic [CW-1:0]               count,
`ifdef VECTOR_STREAM_MASK_EN
    input  logic [LANES-1:0]            mask_in,
`endif
    output logic                        item_valid,
    input  logic                        item_ready,
    output logic [WIDTH-1:0]            item,
    output logic [AW-1:0]               item_idx,
    output logic                        item_last,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    stream_state_t               state_p0;
    logic [LANES-1:0][WIDTH-1:0] shadow_p0;
    logic                        err_p0;

    logic [AW-1:0] idx;
    logic [CW-1:0] rem;
    logic          last;

    logic bad_req;
    logic accept;
    logic load;
    logic run;
    logic lane_on;
    logic vld_p0;
    logic fire;
    logic step;

    assign bad_req = (int'(base) >= LANES) || (int'(stride) >= LANES);
    assign accept  = (state_p0 == IDLE) && start && !bad_req;
    assign load    = accept && (count != '0);
    assign run     = (state_p0 == RUN);

`ifdef VECTOR_STREAM_MASK_EN
    logic [LANES-1:0] mask_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mask_p0 <= '0;
        else if (load)
            mask_p0 <= mask_in;
    end

    assign lane_on = mask_p0[idx];
`else
    assign lane_on = 1'b1;
`endif

    // A masked lane still consumes one visit, but never waits for the consumer.
    assign vld_p0 = run && lane_on;
    assign fire   = vld_p0 && item_ready;
    assign step   = run && (fire || !lane_on);

    lane_index_stepper #(
        .LANES (LANES),
        .AW    (AW),
        .CW    (CW)
    ) u_stepper (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .step   (step),
        .base   (base),
        .stride (stride),
        .count  (count),
        .idx    (idx),
        .rem    (rem),
        .last   (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0  <= IDLE;
            shadow_p0 <= '0;
            err_p0    <= 1'b0;
        end else begin
            err_p0 <= 1'b0;
            case (state_p0)
                IDLE: begin
                    if (start) begin
                        if (bad_req) begin
                            err_p0 <= 1'b1;
                        end else if (count == '0) begin
                            state_p0 <= DONE;
                        end else begin
                            shadow_p0 <= vec_in;
                            state_p0  <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (step && last)
                        state_p0 <= DONE;
                end
                DONE: state_p0 <= IDLE;
                default: state_p0 <= IDLE;
            endcase
        end
    end

    assign item_valid = vld_p0;
    assign item       = run ? shadow_p0[idx] : '0;
    assign item_idx   = run ? idx : '0;
    assign item_last  = run && last;
    assign busy       = (state_p0 != IDLE);
    assign done       = (state_p0 == DONE);
    assign err        = err_p0;

endmodule
